// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: reset/trap vectors,
// the IF/ID record, and the next-PC select encoding.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] INTR_VEC_DEF  = 32'h0000_0004;
  localparam logic [31:0] EXCP_VEC_DEF  = 32'h0000_0008;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int          KERNEL_BIT    = 31;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  typedef enum logic [2:0] {
    SEL_EXCP,
    SEL_INTR,
    SEL_REDIR,
    SEL_HOLD,
    SEL_SEQ
  } next_pc_sel_e;

  // Sequential successor: the kernel bit is carried over untouched and the
  // carry out of the bit just below it is dropped, so mode never flips by increment.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    logic [KERNEL_BIT-1:0] low;
    low = pc[KERNEL_BIT-1:0] + {{(KERNEL_BIT-3){1'b0}}, 3'd4};
    return {pc[KERNEL_BIT], low};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_select.sv
// Combinational next-PC priority encoder: exception/misalign, interrupt,
// redirect, stall hold, sequential.
module next_pc_select
  import instruction_fetch_unit_pkg::*;
(
  input  logic         excp_i,
  input  logic         intr_i,
  input  logic         redirect_i,
  input  logic [1:0]   redirect_lo_i,
  input  logic         stall_i,
  output next_pc_sel_e sel_o,
  output logic         misalign_o
);

  assign misalign_o = redirect_i && (redirect_lo_i != 2'b00);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if-chain can leave it unassigned and infer a latch.
    sel_o = SEL_SEQ;
    if (excp_i || misalign_o) sel_o = SEL_EXCP;
    else if (intr_i)          sel_o = SEL_INTR;
    else if (redirect_i)      sel_o = SEL_REDIR;
    else if (stall_i)         sel_o = SEL_HOLD;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// registers the fetched word into IF/ID; flags misaligned redirect targets.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] INTR_VEC  = INTR_VEC_DEF,
  parameter logic [31:0] EXCP_VEC  = EXCP_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        intr_i,
  input  logic        excp_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        fetch_excp_o,
  output logic [31:0] bad_pc_o
);

  logic [31:0]  pc_q, pc_nxt, pc4;
  ifid_t        ifid_q, ifid_nxt;
  next_pc_sel_e sel;
  logic         misalign;
  logic         bubble, capture;

  next_pc_select u_next_pc_select (
    .excp_i        (excp_i),
    .intr_i        (intr_i),
    .redirect_i    (redirect_i),
    .redirect_lo_i (redirect_pc_i[1:0]),
    .stall_i       (stall_i),
    .sel_o         (sel),
    .misalign_o    (misalign)
  );

  assign pc4 = pc_plus4(pc_q);

  always_comb begin
    pc_nxt  = pc_q;
    bubble  = 1'b0;
    capture = 1'b0;
    unique case (sel)
      SEL_EXCP:  begin pc_nxt = EXCP_VEC;      bubble = 1'b1; end
      SEL_INTR:  begin pc_nxt = INTR_VEC;      bubble = 1'b1; end
      SEL_REDIR: begin pc_nxt = redirect_pc_i; bubble = flush_i; capture = !flush_i; end
      // A flush still empties IF/ID while the PC is held by a stall.
      SEL_HOLD:  bubble = flush_i;
      SEL_SEQ:   begin pc_nxt = pc4;           bubble = flush_i; capture = !flush_i; end
      default:   ;
    endcase

    ifid_nxt = ifid_q;
    if (bubble) begin
      ifid_nxt.instr = NOP_INSTR;
      ifid_nxt.valid = 1'b0;
    end else if (capture) begin
      ifid_nxt = '{instr: imem_data_i, pc: pc_q, pc4: pc4, valid: 1'b1};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VEC;
      ifid_q       <= '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
      fetch_excp_o <= 1'b0;
      bad_pc_o     <= 32'h0;
    end else begin
      pc_q         <= pc_nxt;
      ifid_q       <= ifid_nxt;
      fetch_excp_o <= misalign;
      if (misalign) bad_pc_o <= redirect_pc_i;
    end
  end

  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_pc4_o   = ifid_q.pc4;
  assign ifid_valid_o = ifid_q.valid;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction ROM: owns the program counter, drives the ROM address, and captures the returned word into the IF/ID pipeline register.
- Selects the next PC by a fixed priority: exception vector, interrupt vector, redirect from later stages, stall hold, or PC+4.
- Detects misaligned redirect targets and raises a fetch exception, latching the faulting PC.
- Sits between hazard/branch control and the decode stage of the 5-stage pipeline.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value after reset.
- INTR_VEC, 32'h0000_0004, interrupt handler entry.
- EXCP_VEC, 32'h0000_0008, exception handler entry.
- KERNEL_BIT, 31, PC bit marking kernel mode; preserved from the current PC into PC+4.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous reset, active-low
- stall_i  in  1  hold PC and IF/ID register (load-use hazard)
- flush_i  in  1  load a bubble into IF/ID (taken branch/jump resolved later)
- redirect_i  in  1  load redirect_pc_i into PC
- redirect_pc_i  in  32  branch/jump/jr target
- intr_i  in  1  external interrupt request, level, already masked upstream
- excp_i  in  1  exception request from a later stage
- imem_addr_o  out  32  address to instruction ROM (= PC, combinational)
- imem_data_i  in  32  instruction returned combinationally in the same cycle
- ifid_instr_o  out  32  registered instruction
- ifid_pc_o  out  32  registered PC of that instruction
- ifid_pc4_o  out  32  registered PC+4 (link / EPC source)
- ifid_valid_o  out  1  IF/ID holds a real instruction
- fetch_excp_o  out  1  one-cycle pulse: misaligned redirect detected
- bad_pc_o  out  32  faulting redirect target, held until the next fault

Behaviour:
- Reset (reset=0, asynchronous):
  - PC = RESET_VEC.
  - ifid_instr_o = 0, ifid_pc_o = 0, ifid_pc4_o = 0, ifid_valid_o = 0.
  - fetch_excp_o = 0, bad_pc_o = 0.
- After reset release, the first rising edge captures imem_data_i at RESET_VEC into IF/ID with valid=1.
- Latency is one cycle from PC to IF/ID.
- pc4 = {PC[KERNEL_BIT], PC[30:0]+4}. The carry out of bit 30 is discarded, so the kernel bit never toggles through increment.
- Next-PC priority, evaluated each rising edge:
  1. excp_i=1 or a misaligned redirect (redirect_i=1 and redirect_pc_i[1:0]!=0) -> PC=EXCP_VEC, IF/ID=bubble.
  2. intr_i=1 -> PC=INTR_VEC, IF/ID=bubble.
  3. redirect_i=1 (aligned) -> PC=redirect_pc_i, IF/ID=bubble if flush_i, otherwise captures the current fetch.
  4. stall_i=1 -> PC and IF/ID unchanged.
  5. Otherwise PC=pc4 and IF/ID captures {imem_data_i, PC, pc4, valid=1}.
- Bubble means instr=0 (nop), pc and pc4 keep their old values, valid=0.
- flush_i without redirect_i: IF/ID=bubble and PC advances to pc4, unless stall_i is also asserted. With stall_i=1 the PC holds, but the flush still wins over the stall for the IF/ID register.
- Simultaneous stall_i with any of priorities 1-3: the higher-priority event wins and the stall is ignored for that cycle.
- Misaligned fetch:
  - fetch_excp_o pulses high for exactly the cycle after the offending edge.
  - bad_pc_o loads redirect_pc_i on that edge.
  - A fault during an excp_i cycle still records bad_pc_o.
- Mid-operation reset forces the reset state immediately, independent of clk.
- PC wrap: 32'h7FFF_FFFC + 4 -> 32'h0000_0000; 32'hFFFF_FFFC + 4 -> 32'h8000_0000.
- State machine: RUN/HALT_ON_EXCP is not required. The unit is a pure PC/pipeline-register datapath with the priority mux as its control.

Decomposition:
- Shared package holds:
  - vector constants (RESET/INTR/EXCP);
  - NOP_INSTR = 32'h0;
  - the ifid record typedef {instr, pc, pc4, valid};
  - the next-PC select encoding {SEL_EXCP, SEL_INTR, SEL_REDIR, SEL_HOLD, SEL_SEQ}.
- One sub-module, next_pc_select: combinational priority encoder producing the select code and the misalign flag. The PC and IF/ID registers stay in the top.

Test Plan:
- Reset release, ROM word at 0 = 32'h08000003, no stalls:
  - cycle 1: ifid_pc_o=0, ifid_instr_o=32'h08000003, valid=1;
  - imem_addr_o steps 0, 4, 8, C.
- redirect_i=1, flush_i=1, target 32'h0000000C:
  - next cycle PC=0xC, valid=0;
  - the following cycle ifid_pc_o=0xC.
- stall_i held 3 cycles at PC=0x14: imem_addr_o and all IF/ID outputs frozen; then resumes at 0x18.
- Redirect target 32'h00000026:
  - PC=0x8, fetch_excp_o pulses once, bad_pc_o=0x26, valid=0.
- intr_i and redirect_i together (target 0x40) -> PC=0x4; same with excp_i also high -> PC=0x8.
- Kernel bit and mid-run reset:
  - PC=0xFFFF_FFFC increments to 0x8000_0000;
  - asserting reset mid-cycle immediately zeroes the IF/ID outputs, with PC=0 before the next edge.
